// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared widths, slot geometry and FSM states for the gain scheduler
package dsm_pkg;
    localparam int DATA_W = 36;
    localparam int FRAC_W = 16;
    localparam int COEF_W = 24;
    localparam int NSLOT  = 12;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/gain_mul.sv
// rtl/gain_mul.sv - two-stage sign-magnitude Q8.16 multiplier with idx/valid/last sideband
module gain_mul #(
    parameter int COEF_W = dsm_pkg::COEF_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [dsm_pkg::IDX_W-1:0]  in_idx,
    input  logic [dsm_pkg::DATA_W-1:0] in_data,
    input  logic [COEF_W-1:0]          in_coef,
    input  logic                       in_cg,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [dsm_pkg::IDX_W-1:0]  out_idx,
    output logic [dsm_pkg::DATA_W-1:0] out_data
);
    import dsm_pkg::*;

    localparam int PROD_W = DATA_W + COEF_W;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q,  s1_last_d;
    logic              s1_neg_q,   s1_neg_d;
    logic [IDX_W-1:0]  s1_idx_q,   s1_idx_d;
    logic [PROD_W-1:0] s1_prod_q,  s1_prod_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;
    logic [IDX_W-1:0]  out_idx_q,   out_idx_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] r;

    always_comb begin
        // The most negative operand maps to 2^35, which still fits the unsigned magnitude.
        mag         = in_data[DATA_W-1] ? -in_data : in_data;
        s1_valid_d  = in_valid;
        s1_last_d   = in_valid & in_last;
        s1_idx_d    = in_idx;
        s1_neg_d    = in_data[DATA_W-1] ^ ~in_cg;
        s1_prod_d   = PROD_W'(mag) * PROD_W'(in_coef);

        r           = DATA_W'(s1_prod_q >> FRAC_W);
        out_valid_d = s1_valid_q;
        out_last_d  = s1_last_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        if (s1_valid_q) begin
            out_idx_d  = s1_idx_q;
            out_data_d = s1_neg_q ? -r : r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_idx_q    <= '0;
            s1_prod_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_neg_q    <= s1_neg_d;
            s1_idx_q    <= s1_idx_d;
            s1_prod_q   <= s1_prod_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
endmodule

// File: rtl/gain_sched.sv
// rtl/gain_sched.sv - per-sample coefficient pass sequencer with shadow/active gain banks
module gain_sched #(
    parameter int NSLOT  = dsm_pkg::NSLOT,
    parameter int COEF_W = dsm_pkg::COEF_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [dsm_pkg::IDX_W-1:0]  op_idx,
    input  logic [dsm_pkg::DATA_W-1:0] op_data,
    input  logic                       cfg_we,
    input  logic [dsm_pkg::IDX_W-1:0]  cfg_addr,
    input  logic [COEF_W:0]            cfg_data,
    output logic                       res_valid,
    output logic [dsm_pkg::IDX_W-1:0]  res_idx,
    output logic [dsm_pkg::DATA_W-1:0] res_data,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun,
    input  logic                       overrun_clr
);
    import dsm_pkg::*;

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NSLOT - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] slot_q, slot_d;
    logic             drain_q, drain_d;
    logic             overrun_q, overrun_d;
    logic [COEF_W:0]  shadow_q [NSLOT];
    logic [COEF_W:0]  shadow_d [NSLOT];
    logic [COEF_W:0]  active_q [NSLOT];
    logic [COEF_W:0]  active_d [NSLOT];
    logic [COEF_W:0]  cur_coef;
    logic             issue;

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        drain_d   = drain_q;
        overrun_d = overrun_q;
        shadow_d  = shadow_q;
        active_d  = active_q;

        if (cfg_we && (int'(cfg_addr) < NSLOT)) begin
            shadow_d[cfg_addr] = cfg_data;
        end

        // Set is evaluated last so it wins over a coincident clear.
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (start && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    slot_d   = '0;
                    active_d = shadow_q;
                end
            end
            ST_RUN: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        issue    = (state_q == ST_RUN);
        op_idx   = issue ? slot_q : '0;
        cur_coef = active_q[slot_q];
        busy     = (state_q != ST_IDLE);
        overrun  = overrun_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            drain_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            drain_q   <= drain_d;
            overrun_q <= overrun_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    gain_mul #(
        .COEF_W (COEF_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_last   (slot_q == LAST_SLOT),
        .in_idx    (slot_q),
        .in_data   (op_data),
        .in_coef   (cur_coef[COEF_W-1:0]),
        .in_cg     (cur_coef[COEF_W]),
        .out_valid (res_valid),
        .out_last  (done),
        .out_idx   (res_idx),
        .out_data  (res_data)
    );
endmodule

// File: tb/tb_gain_sched.sv
// tb/tb_gain_sched.sv - randomized self-checking bench for gain_sched
module tb_gain_sched;
    localparam int NSLOT = 12;
    localparam int CW    = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cfg_we = 1'b0;
    logic        overrun_clr = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [CW:0] cfg_data = '0;
    logic [3:0]  op_idx, res_idx;
    logic [35:0] op_data, res_data;
    logic        res_valid, busy, done, overrun;

    logic [35:0] op_mem [16];
    logic [CW:0] shadow_m [NSLOT];
    logic [CW:0] active_m [NSLOT];
    logic        ov_m;
    logic [35:0] res_log [NSLOT];
    int          n_cmp = 0;
    int          n_bad = 0;

    assign op_data = op_mem[op_idx];

    always #5 clk = ~clk;

    gain_sched #(.NSLOT(NSLOT), .COEF_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .op_idx(op_idx), .op_data(op_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
        .busy(busy), .done(done), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    // Signed value = sign * floor(|op| * coef / 2^16), reduced modulo 2^36.
    function automatic logic [35:0] ref_gain(input logic [35:0] op, input logic [CW:0] cfg);
        logic [63:0] mag, q, res;
        logic        neg;
        mag = op[35] ? (64'h10_0000_0000 - 64'(op)) : 64'(op);
        q   = (mag * 64'(cfg[CW-1:0])) >> 16;
        neg = op[35] ^ ~cfg[CW];
        res = neg ? (64'h10_0000_0000 - q) : q;
        return res[35:0];
    endfunction

    function automatic logic [35:0] rand36();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0: return 36'h800000000;
            1: return 36'hFFFFFFFFF;
            default: return v[35:0];
        endcase
    endfunction

    task automatic cfg_write(input logic [3:0] addr, input logic [CW:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
        if (int'(addr) < NSLOT) shadow_m[addr] = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run_pass(input int again_at, input int wr_at, input logic [3:0] wr_addr,
                            input logic [CW:0] wr_data, input int clr_at);
        logic [35:0] exp_d [NSLOT];
        logic        e_busy, e_rv, e_done;
        logic [3:0]  e_idx;
        for (int c = 0; c <= NSLOT + 3; c++) begin
            @(negedge clk);
            e_busy = (c >= 1) && (c <= NSLOT + 2);
            e_idx  = ((c >= 1) && (c <= NSLOT)) ? 4'(c - 1) : 4'd0;
            e_rv   = (c >= 3) && (c <= NSLOT + 2);
            e_done = (c == NSLOT + 2);
            n_cmp++; if (busy !== e_busy) begin n_bad++; $display("FAIL busy c=%0d got %b exp %b", c, busy, e_busy); end
            n_cmp++; if (op_idx !== e_idx) begin n_bad++; $display("FAIL op_idx c=%0d got %0d exp %0d", c, op_idx, e_idx); end
            n_cmp++; if (res_valid !== e_rv) begin n_bad++; $display("FAIL res_valid c=%0d got %b exp %b", c, res_valid, e_rv); end
            n_cmp++; if (done !== e_done) begin n_bad++; $display("FAIL done c=%0d got %b exp %b", c, done, e_done); end
            n_cmp++; if (overrun !== ov_m) begin n_bad++; $display("FAIL overrun c=%0d got %b exp %b", c, overrun, ov_m); end
            if (e_rv) begin
                res_log[c-3] = res_data;
                n_cmp++; if (res_idx !== 4'(c - 3)) begin n_bad++; $display("FAIL res_idx c=%0d got %0d exp %0d", c, res_idx, c - 3); end
                n_cmp++; if (res_data !== exp_d[c-3]) begin n_bad++; $display("FAIL res_data slot=%0d got %h exp %h", c - 3, res_data, exp_d[c-3]); end
            end
            if (c == NSLOT + 3) begin
                n_cmp++; if (res_idx !== 4'(NSLOT - 1)) begin n_bad++; $display("FAIL hold_idx got %0d exp %0d", res_idx, NSLOT - 1); end
                n_cmp++; if (res_data !== exp_d[NSLOT-1]) begin n_bad++; $display("FAIL hold_data got %h exp %h", res_data, exp_d[NSLOT-1]); end
            end
            start       = (c == 0) || (c == again_at);
            overrun_clr = (c == clr_at);
            cfg_we      = (c == wr_at);
            cfg_addr    = wr_addr;
            cfg_data    = wr_data;
            if (c == 0) begin
                active_m = shadow_m;
                for (int k = 0; k < NSLOT; k++) exp_d[k] = ref_gain(op_mem[k], active_m[k]);
            end
            if (cfg_we && int'(wr_addr) < NSLOT) shadow_m[wr_addr] = wr_data;
            if (start && c != 0) ov_m = 1'b1;
            else if (overrun_clr) ov_m = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, done, res_valid, overrun} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got %b exp 0000", {busy, done, res_valid, overrun}); end
        n_cmp++; if (res_data !== 36'h0) begin n_bad++; $display("FAIL reset_res_data got %h exp 0", res_data); end
        n_cmp++; if ({res_idx, op_idx} !== 8'h0) begin n_bad++; $display("FAIL reset_idx got %h exp 00", {res_idx, op_idx}); end
        rst = 1'b0;
        for (int k = 0; k < NSLOT; k++) shadow_m[k] = '0;
        ov_m = 1'b0;
    endtask

    task automatic test_scaling();
        for (int k = 0; k < NSLOT; k++) op_mem[k] = rand36();
        cfg_write(4'd0, {1'b1, 24'h010000}); op_mem[0] = 36'h000012345;
        cfg_write(4'd1, {1'b0, 24'h008000}); op_mem[1] = 36'h000050000;
        cfg_write(4'd2, {1'b1, 24'h008000}); op_mem[2] = 36'hFFFFFFFFF;
        run_pass(-1, -1, 4'd0, '0, -1);
        n_cmp++; if (res_log[0] !== 36'h000012345) begin n_bad++; $display("FAIL s1_unity got %h exp 000012345", res_log[0]); end
        n_cmp++; if (res_log[1] !== 36'hFFFFD8000) begin n_bad++; $display("FAIL s2_gneg got %h exp FFFFD8000", res_log[1]); end
        n_cmp++; if (res_log[2] !== 36'h000000000) begin n_bad++; $display("FAIL s2_trunc got %h exp 000000000", res_log[2]); end
    endtask

    task automatic test_wrap_timing();
        cfg_write(4'd3, {1'b1, 24'h010000}); op_mem[3] = 36'h800000000;
        run_pass(-1, -1, 4'd0, '0, -1);
        n_cmp++; if (res_log[3] !== 36'h800000000) begin n_bad++; $display("FAIL s3_wrap got %h exp 800000000", res_log[3]); end
    endtask

    task automatic test_overrun();
        run_pass(5, -1, 4'd0, '0, -1);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b exp 1", overrun); end
        @(negedge clk); overrun_clr = 1'b1; ov_m = 1'b0;
        @(negedge clk); overrun_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clr got %b exp 0", overrun); end
        run_pass(5, -1, 4'd0, '0, 5);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
        @(negedge clk); overrun_clr = 1'b1; ov_m = 1'b0;
        @(negedge clk); overrun_clr = 1'b0;
    endtask

    task automatic test_shadow_write();
        cfg_write(4'd3, {1'b1, 24'h010000}); op_mem[3] = 36'h100;
        run_pass(-1, 4, 4'd3, {1'b1, 24'h020000}, -1);
        n_cmp++; if (res_log[3] !== 36'h100) begin n_bad++; $display("FAIL s5_old_mid got %h exp 100", res_log[3]); end
        run_pass(-1, 0, 4'd3, {1'b1, 24'h030000}, -1);
        n_cmp++; if (res_log[3] !== 36'h200) begin n_bad++; $display("FAIL s5_new_coinc_old got %h exp 200", res_log[3]); end
        run_pass(-1, 7, 4'd13, {1'b1, 24'hFFFFFF}, -1);
        n_cmp++; if (res_log[3] !== 36'h300) begin n_bad++; $display("FAIL s5_coinc_new got %h exp 300", res_log[3]); end
    endtask

    task automatic test_random();
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 16; k++) cfg_write(4'(k), 25'($urandom()));
            for (int k = 0; k < NSLOT; k++) op_mem[k] = rand36();
            run_pass(-1, int'($urandom_range(0, NSLOT + 2)), 4'($urandom()), 25'($urandom()), -1);
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < NSLOT; k++) cfg_write(4'(k), {1'b1, 24'($urandom_range(1, 24'hFFFFFF))});
        for (int k = 0; k < NSLOT; k++) op_mem[k] = 36'h000100000 + 36'(k);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            start = (c == 0);
            rst   = (c == 4);
        end
        n_cmp++; if ({busy, done, res_valid, overrun} !== 4'b0) begin n_bad++; $display("FAIL abort_flags got %b exp 0000", {busy, done, res_valid, overrun}); end
        n_cmp++; if ({res_data, res_idx, op_idx} !== 44'h0) begin n_bad++; $display("FAIL abort_data got %h exp 0", {res_data, res_idx, op_idx}); end
        rst = 1'b0;
        for (int k = 0; k < NSLOT; k++) shadow_m[k] = '0;
        ov_m = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_cmp++; if ((res_valid | done) !== 1'b0) begin n_bad++; $display("FAIL abort_quiet c=%0d got rv=%b done=%b exp 0", c, res_valid, done); end
        end
        for (int k = 0; k < NSLOT; k++) op_mem[k] = rand36();
        run_pass(-1, -1, 4'd0, '0, -1);
        n_cmp++; if (res_log[5] !== 36'h0) begin n_bad++; $display("FAIL abort_zero_coef got %h exp 0", res_log[5]); end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) op_mem[k] = '0;
        for (int k = 0; k < NSLOT; k++) shadow_m[k] = '0;
        ov_m = 1'b0;
        test_reset();
        test_scaling();
        test_wrap_timing();
        test_overrun();
        test_shadow_write();
        test_random();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gain_sched.md
GAIN_SCHED -- requirements
Module: gain_sched

Interface
REQ-001 Parameter NSLOT, default 12, SHALL set the number of coefficient slots (6th-order loop: 6 C-gains plus 6 G-gains).
REQ-002 Parameter COEF_W, default 24, SHALL set the unsigned coefficient magnitude width, format Q8.16.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL be updated on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL request one full pass over all slots for the current sample.
REQ-006 op_idx  output  4  SHALL carry the index of the slot whose operand is being fetched.
REQ-007 op_data  input  36  SHALL be the two's-complement operand for slot op_idx, valid in the same cycle (combinational fetch).
REQ-008 cfg_we  input  1  SHALL be the shadow coefficient write strobe.
REQ-009 cfg_addr  input  4  SHALL be the slot index for the write.
REQ-010 cfg_data  input  COEF_W+1  SHALL carry the write data: bit COEF_W is the CG flag (1 = C-type, result kept; 0 = G-type, result negated), and the low bits are the magnitude.
REQ-011 res_valid  output  1  SHALL be a one-cycle qualifier for res_idx and res_data.
REQ-012 res_idx  output  4  SHALL carry the slot index of the result.
REQ-013 res_data  output  36  SHALL carry the scaled, two's-complement result.
REQ-014 busy  output  1  SHALL be high while a pass is in progress.
REQ-015 done  output  1  SHALL pulse for one cycle with the last result of a pass.
REQ-016 overrun  output  1  SHALL be a sticky flag that is set when start arrives while busy is high.
REQ-017 overrun_clr  input  1  SHALL clear overrun.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DRAIN: IDLE to RUN on start; RUN to DRAIN after issuing slot NSLOT-1; DRAIN to IDLE once the pipeline has emptied (2 cycles).
REQ-019 On start accepted in cycle 0, the block SHALL copy the shadow coefficient bank to the active bank in the same edge; a pass SHALL use only the active bank.
REQ-020 In RUN, the block SHALL issue exactly one slot per cycle: slot k at cycle k+1, with op_idx=k and op_data sampled in that cycle.
REQ-021 Outside RUN, op_idx SHALL hold 0.
REQ-022 The arithmetic SHALL be: mag=|op_data| as unsigned 36 bits (0x800000000 gives 2^35); p=mag*coef (60 bits); r=p[51:16]; r SHALL be two's-complement negated if op_data[35]=1; the result SHALL then be negated again if CG=0. The effect is truncation toward zero, with wrap modulo 2^36 and no saturation.
REQ-023 Latency SHALL be 2 cycles from issue: slot k result at cycle k+3, in slot order, with no gaps.
REQ-024 done SHALL be asserted in cycle NSLOT+2 together with res_valid for slot NSLOT-1.
REQ-025 busy SHALL be high in cycles 1..NSLOT+2.
REQ-026 A start in cycle NSLOT+3 or later SHALL be accepted.
REQ-027 A start while busy SHALL be ignored and SHALL set overrun; the current pass SHALL be unaffected.
REQ-028 If overrun_clr and a set condition occur in the same cycle, set SHALL win.
REQ-029 cfg_we SHALL be accepted in any state and SHALL write only the shadow bank.
REQ-030 If cfg_we and start occur in the same cycle, the pass SHALL use the pre-write value, and the write SHALL land in the shadow bank.
REQ-031 cfg_addr >= NSLOT SHALL be ignored.
REQ-032 res_data and res_idx SHALL hold their last values while res_valid=0.

Reset
REQ-033 rst SHALL force IDLE; busy, done, res_valid, overrun=0; res_data, res_idx, op_idx=0; pipeline valids cleared.
REQ-034 rst SHALL clear both coefficient banks to 0 with CG=0.
REQ-035 rst asserted mid-pass SHALL abort the pass, and no further res_valid or done SHALL be emitted.

Structure
REQ-036 Package dsm_pkg SHALL hold DATA_W=36, FRAC_W=16, COEF_W, NSLOT, the slot-index width and the FSM state enum.
REQ-037 The two-stage multiplier SHALL be a sub-module gain_mul (stage 1: abs and multiply; stage 2: slice, sign restore and CG negate) carrying valid and idx alongside the data.

Verification
REQ-038 Scenario 1: slot 0 set to CG=1, coef 0x010000, op 0x000012345, start -> res_data 0x000012345 at cycle 3, idx 0.
REQ-039 Scenario 2: slot 1 set to CG=0, coef 0x008000, op 0x000050000 -> res_data 0xFFFFD8000; op 0xFFFFFFFFF with CG=1, coef 0x008000 -> 0x000000000 (truncation toward zero).
REQ-040 Scenario 3: op 0x800000000, CG=1, coef 0x010000 -> 0x800000000 (wrap, no saturation); the bench SHALL also check that all NSLOT results appear at cycles 3..NSLOT+2 and that done appears at cycle NSLOT+2.
REQ-041 Scenario 4: start pulsed at cycle 5 of a pass -> pass unchanged and overrun=1; overrun_clr -> overrun=0; simultaneous overrun_clr and overrun set -> overrun=1.
REQ-042 Scenario 5: cfg_we changes slot 3 mid-pass -> the current pass uses the old coefficient and the next pass uses the new one; a write coincident with start behaves the same.
REQ-043 Scenario 6: rst asserted at cycle 4 of a pass -> next cycle all outputs are 0 and in IDLE, with no res_valid or done afterwards; a following start yields results with coefficient 0, i.e. res_data=0.
